// File: rtl/pusch_ls_chest_if.sv
// Port bundle for pusch_ls_chest: slot configuration, received RE stream,
// DMRS reference memory port, LS estimate outputs and data-symbol passthrough.
interface pusch_ls_chest_if #(
  parameter int DATA_WIDTH = 26,
  parameter int DMRS_Len   = 9,
  parameter int OUT_WIDTH  = 26
);
  logic                         Start;
  logic [6:0]                   N_rb;
  logic [3:0]                   Sym_Start;
  logic [3:0]                   Sym_End;
  logic [3:0]                   Dmrs_Sym;

  logic signed [DATA_WIDTH-1:0] Rx_I;
  logic signed [DATA_WIDTH-1:0] Rx_Q;
  logic                         Rx_Valid;

  logic signed [DMRS_Len-1:0]   Ref_I;
  logic signed [DMRS_Len-1:0]   Ref_Q;
  logic [9:0]                   Ref_addr;

  logic signed [OUT_WIDTH-1:0]  H_I;
  logic signed [OUT_WIDTH-1:0]  H_Q;
  logic                         H_Valid;
  logic [9:0]                   H_idx;

  logic signed [DATA_WIDTH-1:0] D_I;
  logic signed [DATA_WIDTH-1:0] D_Q;
  logic                         D_Valid;
  logic [3:0]                   D_sym;

  logic                         Chest_Done;

  // Upstream side: RE mapper, slot controller and DMRS memory.
  modport master (
    output Start, N_rb, Sym_Start, Sym_End, Dmrs_Sym,
    output Rx_I, Rx_Q, Rx_Valid,
    output Ref_I, Ref_Q,
    input  Ref_addr,
    input  H_I, H_Q, H_Valid, H_idx,
    input  D_I, D_Q, D_Valid, D_sym,
    input  Chest_Done
  );

  modport slave (
    input  Start, N_rb, Sym_Start, Sym_End, Dmrs_Sym,
    input  Rx_I, Rx_Q, Rx_Valid,
    input  Ref_I, Ref_Q,
    output Ref_addr,
    output H_I, H_Q, H_Valid, H_idx,
    output D_I, D_Q, D_Valid, D_sym,
    output Chest_Done
  );
endinterface

// File: rtl/pusch_ls_chest.sv
// PUSCH least-squares channel estimator: H = Y*conj(X) on even DMRS subcarriers, data REs passed through.
// Optional macro CHEST_SAT_EN: saturate the final width reduction instead of wrapping.
module pusch_ls_chest #(
  parameter int DATA_WIDTH = 26,
  parameter int DMRS_Len   = 9,
  parameter int OUT_WIDTH  = 26,
  parameter int SHIFT      = 8
) (
  input logic             CLK,
  input logic             RST,
  pusch_ls_chest_if.slave bus
);

  localparam int PW = DATA_WIDTH + DMRS_Len + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;

  logic [10:0] re_cnt;
  logic [10:0] n_re;
  logic [10:0] n_re_in;
  logic [3:0]  sym_cnt;
  logic [3:0]  sym_end;
  logic [3:0]  dmrs_sym;
  logic [9:0]  dmrs_cnt;
  logic [9:0]  ref_addr_q;
  logic [1:0]  flush_cnt;

  logic        start_ok;
  logic        accept;
  logic        last_re;
  logic        is_dmrs;
  logic        rd_ref;
  logic        take_d;

  assign n_re_in = 11'(bus.N_rb) * 11'd12;
  assign last_re = (re_cnt == n_re - 11'd1);
  assign is_dmrs = (sym_cnt == dmrs_sym);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    start_ok = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          if (bus.N_rb == '0 || bus.Sym_End < bus.Sym_Start) begin
            state_d = DONE;
          end else begin
            start_ok = 1'b1;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (bus.Rx_Valid) begin
          accept = 1'b1;
          if (last_re && sym_cnt == sym_end) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_cnt == 2'd2) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Odd subcarriers of the DMRS symbol carry no comb-0 pilot and are dropped.
  assign rd_ref = accept && is_dmrs && !re_cnt[0];
  assign take_d = accept && !is_dmrs;

  assign bus.Ref_addr   = rd_ref ? dmrs_cnt : ref_addr_q;
  assign bus.Chest_Done = (state_q == DONE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      re_cnt     <= '0;
      n_re       <= '0;
      sym_cnt    <= '0;
      sym_end    <= '0;
      dmrs_sym   <= '0;
      dmrs_cnt   <= '0;
      ref_addr_q <= '0;
      flush_cnt  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      if (start_ok) begin
        n_re     <= n_re_in;
        sym_end  <= bus.Sym_End;
        dmrs_sym <= bus.Dmrs_Sym;
        sym_cnt  <= bus.Sym_Start;
        re_cnt   <= '0;
        dmrs_cnt <= '0;
      end else if (accept) begin
        if (last_re) begin
          re_cnt  <= '0;
          sym_cnt <= sym_cnt + 4'd1;
        end else begin
          re_cnt <= re_cnt + 11'd1;
        end
        if (rd_ref) begin
          dmrs_cnt   <= dmrs_cnt + 10'd1;
          ref_addr_q <= dmrs_cnt;
        end
      end
      flush_cnt <= (state_q == FLUSH) ? flush_cnt + 2'd1 : 2'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: S1 capture, S2 complex product, S3 scale and reduce
  // ---------------------------------------------------------------------------
  logic                         s1_h, s1_d;
  logic signed [DATA_WIDTH-1:0] s1_i, s1_q;
  logic [9:0]                   s1_tag;

  logic                         s2_h, s2_d;
  logic signed [PW-1:0]         s2_pi, s2_pq;
  logic signed [DATA_WIDTH-1:0] s2_i, s2_q;
  logic [9:0]                   s2_tag;

  logic signed [PW-1:0]         rx_i_x, rx_q_x, ref_i_x, ref_q_x;
  logic signed [PW-1:0]         p_i, p_q;

  always_comb begin
    rx_i_x  = {{(PW-DATA_WIDTH){s1_i[DATA_WIDTH-1]}}, s1_i};
    rx_q_x  = {{(PW-DATA_WIDTH){s1_q[DATA_WIDTH-1]}}, s1_q};
    ref_i_x = {{(PW-DMRS_Len){bus.Ref_I[DMRS_Len-1]}}, bus.Ref_I};
    ref_q_x = {{(PW-DMRS_Len){bus.Ref_Q[DMRS_Len-1]}}, bus.Ref_Q};
    // Y * conj(X)
    p_i = rx_i_x * ref_i_x + rx_q_x * ref_q_x;
    p_q = rx_q_x * ref_i_x - rx_i_x * ref_q_x;
  end

  function automatic logic signed [OUT_WIDTH-1:0] reduce(input logic signed [PW-1:0] p);
`ifdef CHEST_SAT_EN
    logic signed [PW-1:0] s;
    s = p >>> SHIFT;
    // In range when all bits above the output sign bit agree with it.
    if ((&s[PW-1:OUT_WIDTH-1]) || !(|s[PW-1:OUT_WIDTH-1])) begin
      return s[OUT_WIDTH-1:0];
    end else if (s[PW-1]) begin
      return {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      return {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
`else
    return OUT_WIDTH'(p >>> SHIFT);
`endif
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      // NOTE: datapath registers are reset as well, so an aborted slot leaves nothing on the outputs.
      s1_h        <= 1'b0;
      s1_d        <= 1'b0;
      s1_i        <= '0;
      s1_q        <= '0;
      s1_tag      <= '0;
      s2_h        <= 1'b0;
      s2_d        <= 1'b0;
      s2_pi       <= '0;
      s2_pq       <= '0;
      s2_i        <= '0;
      s2_q        <= '0;
      s2_tag      <= '0;
      bus.H_Valid <= 1'b0;
      bus.H_I     <= '0;
      bus.H_Q     <= '0;
      bus.H_idx   <= '0;
      bus.D_Valid <= 1'b0;
      bus.D_I     <= '0;
      bus.D_Q     <= '0;
      bus.D_sym   <= '0;
    end else begin
      s1_h <= rd_ref;
      s1_d <= take_d;
      if (rd_ref || take_d) begin
        s1_i   <= bus.Rx_I;
        s1_q   <= bus.Rx_Q;
        s1_tag <= rd_ref ? dmrs_cnt : {6'd0, sym_cnt};
      end

      // Reference arrives this cycle, aligned with the S1 sample.
      s2_h <= s1_h;
      s2_d <= s1_d;
      if (s1_h) begin
        s2_pi <= p_i;
        s2_pq <= p_q;
      end
      if (s1_h || s1_d) begin
        s2_i   <= s1_i;
        s2_q   <= s1_q;
        s2_tag <= s1_tag;
      end

      bus.H_Valid <= s2_h;
      bus.D_Valid <= s2_d;
      if (s2_h) begin
        bus.H_I   <= reduce(s2_pi);
        bus.H_Q   <= reduce(s2_pq);
        bus.H_idx <= s2_tag;
      end
      if (s2_d) begin
        bus.D_I   <= s2_i;
        bus.D_Q   <= s2_q;
        bus.D_sym <= s2_tag[3:0];
      end
    end
  end

endmodule

// File: tb/tb_pusch_ls_chest.sv
// Self-checking bench for pusch_ls_chest: random slots against a subcarrier-level LS model,
// with a scoreboard queue drained by an output monitor.
module tb_pusch_ls_chest;

  localparam int DW = 26;
  localparam int RW = 9;
  localparam int OW = 26;
  localparam int SH = 8;

  localparam int MODE_CONST = 0;  // Rx=(100,0),  Ref=(1,0)
  localparam int MODE_PAIR  = 1;  // Rx=(3,4),    Ref=(1,-1)
  localparam int MODE_MAX   = 2;  // Rx=(2^25-1,2^25-1), Ref=(255,255)
  localparam int MODE_RAND  = 3;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  pusch_ls_chest_if #(.DATA_WIDTH(DW), .DMRS_Len(RW), .OUT_WIDTH(OW)) bus ();

  pusch_ls_chest #(
    .DATA_WIDTH(DW),
    .DMRS_Len  (RW),
    .OUT_WIDTH (OW),
    .SHIFT     (SH)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    bit     is_h;
    int     tag;
    longint a;
    longint b;
  } exp_t;

  exp_t sb[$];

  int n_cmp    = 0;
  int n_err    = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  logic signed [RW-1:0] mem_i [1024];
  logic signed [RW-1:0] mem_q [1024];

  always @(posedge CLK) cyc <= cyc + 1;

  // DMRS memory: one-cycle read latency.
  always @(posedge CLK) begin
    bus.Ref_I <= mem_i[bus.Ref_addr];
    bus.Ref_Q <= mem_q[bus.Ref_addr];
  end

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // LS estimate reduction: arithmetic shift, then wrap or clamp to OW bits.
  function automatic longint red(input longint p);
    longint s;
    longint m;
    s = p >>> SH;
`ifdef CHEST_SAT_EN
    m = s;
    if (s > (longint'(1) <<< (OW-1)) - 1) m = (longint'(1) <<< (OW-1)) - 1;
    if (s < -(longint'(1) <<< (OW-1)))    m = -(longint'(1) <<< (OW-1));
`else
    m = s & ((longint'(1) <<< OW) - 1);
    if (m >= (longint'(1) <<< (OW-1))) m = m - (longint'(1) <<< OW);
`endif
    return m;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_h_valid"},    bus.H_Valid,    0);
    check({tag, "_h_i"},        bus.H_I,        0);
    check({tag, "_h_q"},        bus.H_Q,        0);
    check({tag, "_h_idx"},      bus.H_idx,      0);
    check({tag, "_d_valid"},    bus.D_Valid,    0);
    check({tag, "_d_i"},        bus.D_I,        0);
    check({tag, "_d_q"},        bus.D_Q,        0);
    check({tag, "_d_sym"},      bus.D_sym,      0);
    check({tag, "_chest_done"}, bus.Chest_Done, 0);
    check({tag, "_ref_addr"},   bus.Ref_addr,   0);
  endtask

  // Output monitor: every presented output must match the oldest expectation.
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (RST) begin
      if (bus.H_Valid || bus.D_Valid) begin
        check("hd_exclusive", bus.H_Valid & bus.D_Valid, 0);
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got H_Valid=%0b D_Valid=%0b, required no output at t=%0t",
                   bus.H_Valid, bus.D_Valid, $time);
        end else begin
          e = sb.pop_front();
          check("out_kind_h", bus.H_Valid, e.is_h);
          if (e.is_h) begin
            check("h_idx", bus.H_idx, e.tag);
            check("h_i",   bus.H_I,   e.a);
            check("h_q",   bus.H_Q,   e.b);
          end else begin
            check("d_sym", bus.D_sym, e.tag);
            check("d_i",   bus.D_I,   e.a);
            check("d_q",   bus.D_Q,   e.b);
          end
        end
      end
      if (bus.Chest_Done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // One slot: Start, every allocated RE (with optional random gaps), then Chest_Done timing.
  // mid_start_at pulses an extra Start on that RE; abort_at resets asynchronously after that RE.
  task automatic run_slot(input int n_rb, input int s0, input int s1, input int dm,
                          input int mode, input int gap_max, input int mid_start_at, input int abort_at);
    int                   n;
    int                   k;
    int                   last_cyc;
    int                   done0;
    logic signed [DW-1:0] yi;
    logic signed [DW-1:0] yq;
    exp_t                 e;

    for (int a = 0; a < 1024; a++) begin
      case (mode)
        MODE_CONST: begin mem_i[a] = 9'sd1;   mem_q[a] = 9'sd0;   end
        MODE_PAIR:  begin mem_i[a] = 9'sd1;   mem_q[a] = -9'sd1;  end
        MODE_MAX:   begin mem_i[a] = 9'sd255; mem_q[a] = 9'sd255; end
        default:    begin mem_i[a] = RW'($urandom); mem_q[a] = RW'($urandom); end
      endcase
    end

    done0 = done_cnt;
    n     = 0;
    @(negedge CLK);
    bus.Start     = 1'b1;
    bus.N_rb      = 7'(n_rb);
    bus.Sym_Start = 4'(s0);
    bus.Sym_End   = 4'(s1);
    bus.Dmrs_Sym  = 4'(dm);
    bus.Rx_Valid  = 1'b0;
    last_cyc      = cyc;

    if (n_rb > 0 && s1 >= s0) begin
      for (int s = s0; s <= s1; s++) begin
        for (int r = 0; r < 12 * n_rb; r++) begin
          if (gap_max > 0) begin
            repeat ($urandom_range(0, gap_max)) begin
              @(negedge CLK);
              bus.Start    = 1'b0;
              bus.Rx_Valid = 1'b0;
              bus.Rx_I     = DW'($urandom);
              bus.Rx_Q     = DW'($urandom);
            end
          end
          @(negedge CLK);
          bus.Start = 1'b0;
          if (n == mid_start_at) begin
            bus.Start     = 1'b1;
            bus.N_rb      = 7'd1;
            bus.Sym_Start = 4'd0;
            bus.Sym_End   = 4'd0;
            bus.Dmrs_Sym  = 4'd0;
          end
          case (mode)
            MODE_CONST: begin yi = 26'sd100; yq = 26'sd0; end
            MODE_PAIR:  begin yi = 26'sd3;   yq = 26'sd4; end
            MODE_MAX:   begin yi = 26'sd33554431; yq = 26'sd33554431; end
            default:    begin yi = DW'($urandom); yq = DW'($urandom); end
          endcase
          bus.Rx_Valid = 1'b1;
          bus.Rx_I     = yi;
          bus.Rx_Q     = yq;
          last_cyc     = cyc;

          if (s == dm) begin
            if (r % 2 == 0) begin
              k      = r / 2;
              e.is_h = 1'b1;
              e.tag  = k;
              e.a    = red(longint'(yi) * longint'(mem_i[k]) + longint'(yq) * longint'(mem_q[k]));
              e.b    = red(longint'(yq) * longint'(mem_i[k]) - longint'(yi) * longint'(mem_q[k]));
              sb.push_back(e);
              #1;
              check("ref_addr", bus.Ref_addr, k);
            end
          end else begin
            e.is_h = 1'b0;
            e.tag  = s;
            e.a    = longint'(yi);
            e.b    = longint'(yq);
            sb.push_back(e);
          end

          n++;
          if (n == abort_at) begin
            #2;
            RST = 1'b0;
            #1;
            check_all_zero("abort");
            sb.delete();
            @(negedge CLK);
            bus.Rx_Valid = 1'b0;
            bus.Start    = 1'b0;
            @(negedge CLK);
            RST = 1'b1;
            return;
          end
        end
      end
    end

    for (int i = 0; i < 16 && done_cnt == done0; i++) begin
      @(negedge CLK);
      bus.Start    = 1'b0;
      bus.Rx_Valid = 1'b0;
    end
    repeat (3) @(negedge CLK);
    check("done_count", done_cnt - done0, 1);
    if (done_cnt != done0) begin
      check("done_latency", done_cyc - last_cyc, (n_rb > 0 && s1 >= s0) ? 4 : 1);
    end
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    bus.Start     = 1'b0;
    bus.N_rb      = '0;
    bus.Sym_Start = '0;
    bus.Sym_End   = '0;
    bus.Dmrs_Sym  = '0;
    bus.Rx_Valid  = 1'b0;
    bus.Rx_I      = '0;
    bus.Rx_Q      = '0;
    for (int a = 0; a < 1024; a++) begin
      mem_i[a] = '0;
      mem_q[a] = '0;
    end

    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b1;

    // Empty allocation and inverted symbol range: Chest_Done only.
    run_slot(0, 0, 3, 2, MODE_CONST, 0, -1, -1);
    check("ref_addr_idle", bus.Ref_addr, 0);
    run_slot(2, 5, 3, 4, MODE_CONST, 0, -1, -1);

    // Directed slots.
    run_slot(1, 0, 3, 2, MODE_CONST, 0, -1, -1);
    run_slot(1, 0, 1, 0, MODE_PAIR,  0, -1, -1);
    run_slot(1, 2, 3, 2, MODE_MAX,   0, -1, -1);

    // Random gaps, DMRS on the first symbol, stray Start mid-run.
    run_slot(4, 3, 6, 3, MODE_RAND, 3, 30, -1);
    // DMRS symbol outside the allocation: everything is data.
    run_slot(2, 1, 3, 9, MODE_RAND, 2, -1, -1);

    // Reset in the middle of the DMRS symbol, then a clean slot.
    run_slot(2, 1, 3, 1, MODE_RAND, 1, -1, 15);
    check_all_zero("post_abort");
    run_slot(2, 1, 3, 1, MODE_RAND, 1, -1, -1);

    repeat (5) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pusch_ls_chest.md
Name: pusch_ls_chest

Overview:
- Sits directly downstream of the resource-element mapper / ping-pong memory pair.
- Consumes the per-symbol stream of allocated REs.
- On the DMRS symbol, forms least-squares channel estimates H = Y·conj(X) on comb-0 (even) subcarriers, using reference DMRS fetched from the DMRS memory.
- Forwards data-symbol REs unchanged, and delay-matched, to the equalizer path.

Parameters:
- DATA_WIDTH, 26, width of received I/Q samples.
- DMRS_Len, 9, width of reference DMRS I/Q.
- OUT_WIDTH, 26, width of H_I/H_Q outputs.
- SHIFT, 8, arithmetic right shift applied to the complex product before width reduction.

Ports:
- CLK  in  1  block clock.
- RST  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle pulse; latches N_rb, Sym_Start, Sym_End, Dmrs_Sym.
- N_rb  in  7  allocated RBs; REs per symbol N_re = 12·N_rb.
- Sym_Start  in  4  first allocated symbol index.
- Sym_End  in  4  last allocated symbol index.
- Dmrs_Sym  in  4  index of the DMRS symbol.
- Rx_I, Rx_Q  in  DATA_WIDTH  signed received RE.
- Rx_Valid  in  1  qualifies Rx_I/Rx_Q.
- Ref_I, Ref_Q  in  DMRS_Len  signed reference DMRS; valid exactly 1 cycle after Ref_addr.
- Ref_addr  out  10  DMRS memory read address.
- H_I, H_Q  out  OUT_WIDTH  signed LS estimate.
- H_Valid  out  1  qualifies H_I/H_Q.
- H_idx  out  10  estimate index 0..6·N_rb−1.
- D_I, D_Q  out  DATA_WIDTH  data-symbol RE passthrough.
- D_Valid  out  1  qualifies D_I/D_Q.
- D_sym  out  4  symbol index of the D_* sample.
- Chest_Done  out  1  one-cycle end-of-slot pulse.

Behaviour:
- Reset:
  - All outputs 0; FSM in IDLE.
  - Counters re_cnt (11b), sym_cnt (4b) and dmrs_cnt (10b) all 0.
  - Reset mid-operation aborts immediately; pipeline contents are discarded.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE→RUN on Start: sym_cnt=Sym_Start, re_cnt=0, dmrs_cnt=0.
  - Start with N_rb=0 or Sym_End<Sym_Start goes IDLE→DONE directly; Chest_Done pulses the next cycle and no outputs are produced.
  - Start received outside IDLE is ignored. Rx_Valid in IDLE/FLUSH/DONE is ignored.
  - RUN: each accepted Rx_Valid increments re_cnt.
    - At re_cnt=N_re−1: re_cnt→0, sym_cnt+1.
    - If sym_cnt=Sym_End at that point: go to FLUSH.
  - FLUSH: hold 3 cycles to drain the pipeline, then go to DONE.
  - DONE: Chest_Done=1 for exactly one cycle, then IDLE.
- Symbol classification on the accepted sample:
  - DMRS symbol (sym_cnt==Dmrs_Sym):
    - Even re_cnt: Ref_addr=dmrs_cnt is driven combinationally in the accept cycle, then dmrs_cnt increments.
    - Odd re_cnt: the RE is dropped, with no output of any kind.
  - Data symbol: the RE goes to the D_* path.
  - Dmrs_Sym outside [Sym_Start, Sym_End]: no H output is produced and every symbol is treated as data.
- Pipeline, total latency 3 cycles (sample accepted at cycle t → H_Valid or D_Valid at t+3):
  - S1: register Rx and tags; Ref arrives.
  - S2: compute the full-precision complex product, width DATA_WIDTH+DMRS_Len+1 = 36 bits:
    - P_I = Rx_I·Ref_I + Rx_Q·Ref_Q
    - P_Q = Rx_Q·Ref_I − Rx_I·Ref_Q
  - S3: arithmetic shift right by SHIFT, reduce to OUT_WIDTH, register.
  - The D path is delayed by the same 3 registers, so output order equals input order.
- Outputs:
  - H_idx equals the dmrs_cnt value at accept.
  - D_sym equals the sym_cnt value at accept.
  - H_Valid and D_Valid are never both 1 in the same cycle.
- Ref_addr holds its last value when not reading.
- Back-to-back Rx_Valid is supported at 1 RE/cycle; gaps in Rx_Valid are allowed anywhere.

Optional Feature:
- Macro CHEST_SAT_EN.
- Defined: the S3 reduction saturates to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1].
- Undefined: the S3 reduction keeps the low OUT_WIDTH bits (two's-complement wrap).
- Latency is 3 cycles in both builds.

Test Plan:
- N_rb=1, Sym 0..3, Dmrs_Sym=2, Rx=(100,0) constant, Ref=(1,0):
  - 6 H outputs, H_idx 0..5, H_I=0 (100>>8), H_Q=0.
  - 36 D outputs, D_sym 0,1,3.
  - Chest_Done once, 4 cycles after the last accepted RE.
- SHIFT=0 variant, Rx=(3,4), Ref=(1,−1) → H=(−1,7) on every even RE; odd REs produce no output.
- Rx=(2^25−1, 2^25−1), Ref=(255,255), SHIFT=8 → CHEST_SAT_EN: H_I=2^25−1; without it: wrapped low 26 bits (bench computes).
- Start with N_rb=0 → no H/D output; Chest_Done exactly 1 cycle later; Ref_addr stays 0.
- Random Rx_Valid gaps, N_rb=4, Dmrs_Sym=Sym_Start:
  - Ref_addr sequence 0..23 contiguous.
  - Output order and values match the model.
  - Second Start pulsed mid-run is ignored.
- RST asserted mid-DMRS symbol → all outputs 0 asynchronously; after release, a new Start runs a clean slot with H_idx restarting at 0.
